// File: rtl/pll_sweep_ctrl.sv
// Purpose : SDRAM memtest frequency-sweep control: step index, PLL-reconfig ROM handshake, auto sweep, BCD minutes.
// Latency : button/start events act the cycle after the edge; rc_write_from_rom one cycle after a request, rc_reconfig two after that.
// Backpress: rc_busy stalls the handshake; WAIT_DONE gives up after RECFG_TIMEOUT cycles and pulses rc_reset.
//
// Ports: clock_50_i/RESET (sync, active-high); btn_up/btn_down/btn_auto debounced levels, edge-detected here;
//        start_auto forces a sweep from pos 0; pass_nz/fail_nz tester status; rc_busy/rc_write_from_rom/
//        rc_reconfig/rc_reset talk to the pll_reconfig core; recfg holds the tester in reset during a handshake;
//        pos/auto_on/auto_done/best_pos sweep state; mins (BCD) and ticks (100 ms) elapsed time; to_count timeouts.
// Optional: define PLL_SWEEP_STATS_EN to count WAIT_DONE timeouts in to_count (otherwise tied to 0).
module pll_sweep_ctrl #(
    parameter int NUM_STEPS     = 11,
    parameter int POS_W         = 4,
    parameter int DEF_POS       = 7,
    parameter int CLK_HZ        = 50000000,
    parameter int RECFG_TIMEOUT = 1000,
    parameter int DWELL_TICKS   = 600
) (
    input  logic             clock_50_i,
    input  logic             RESET,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_auto,
    input  logic             start_auto,
    input  logic             pass_nz,
    input  logic             fail_nz,
    input  logic             rc_busy,
    output logic             rc_write_from_rom,
    output logic             rc_reconfig,
    output logic             rc_reset,
    output logic             recfg,
    output logic [POS_W-1:0] pos,
    output logic             auto_on,
    output logic             auto_done,
    output logic [POS_W-1:0] best_pos,
    output logic [15:0]      mins,
    output logic [2:0]       ticks,
    output logic [7:0]       to_count
);
    localparam int TICK_DIV = (CLK_HZ / 10 > 0) ? CLK_HZ / 10 : 1;
    localparam int PS_W     = $clog2(TICK_DIV + 1);
    localparam int TO_W     = $clog2(RECFG_TIMEOUT + 1);
    localparam int DW_W     = $clog2(DWELL_TICKS + 1);

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(RECFG_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [DW_W-1:0]  DW_LAST   = DW_W'(DWELL_TICKS - 1);
    localparam logic [DW_W-1:0]  DW_ONE    = DW_W'(1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_STEPS - 1);
    localparam logic [POS_W-1:0] POS_DEF   = POS_W'(DEF_POS);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);
    localparam logic [9:0]       TICK_LAST = 10'd599;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    logic             pending;
    logic             btn_up_q, btn_down_q, btn_auto_q;
    logic [TO_W-1:0]  to_cnt;
    logic [PS_W-1:0]  prescale;
    logic [9:0]       tick_cnt;
    logic [DW_W-1:0]  dwell_cnt;

    logic             up_edge, down_edge, auto_edge;
    logic             auto_ok, tick, to_fire;
    logic [TO_W-1:0]  to_nxt;
    logic             req, auto_req, clr_done, accept;
    logic [POS_W-1:0] pos_req;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Request decode, highest priority first; at most one request per cycle.
    always_comb begin
        up_edge   = btn_up & ~btn_up_q;
        down_edge = btn_down & ~btn_down_q;
        auto_edge = btn_auto & ~btn_auto_q;
        auto_ok   = auto_on & ~auto_done & ~recfg;
        tick      = ~recfg & (prescale == PS_LAST);
        to_nxt    = to_cnt - TO_ONE;
        // rc_reset must land RECFG_TIMEOUT-1 cycles after rc_reconfig, so fire when the next count is 1.
        to_fire   = (state == WAIT_DONE) && (to_nxt == TO_ONE);

        req      = 1'b0;
        pos_req  = pos;
        auto_req = auto_on;
        clr_done = 1'b0;
        accept   = 1'b0;
        if (start_auto) begin
            req = 1'b1; pos_req = '0; auto_req = 1'b1; clr_done = 1'b1;
        end else if (auto_edge && auto_on) begin
            req = 1'b1; auto_req = 1'b0;
        end else if (auto_edge) begin
            req = 1'b1; pos_req = '0; auto_req = 1'b1; clr_done = 1'b1;
        end else if (up_edge && pos != '0) begin
            req = 1'b1; pos_req = pos - POS_ONE; auto_req = 1'b0;
        end else if (down_edge && pos < POS_LAST) begin
            req = 1'b1; pos_req = pos + POS_ONE; auto_req = 1'b0;
        end else if (auto_ok && pass_nz && fail_nz) begin
            // A failing step: move one slower, or give up at the slowest step.
            if (pos < POS_LAST) begin
                req = 1'b1; pos_req = pos + POS_ONE;
            end else begin
                accept = 1'b1;
            end
        end else if (auto_ok && !fail_nz && tick && dwell_cnt == DW_LAST) begin
            accept = 1'b1;
        end
    end

    always_ff @(posedge clock_50_i) begin
        if (RESET) begin
            state             <= IDLE;
            pending           <= 1'b0;
            btn_up_q          <= 1'b0;
            btn_down_q        <= 1'b0;
            btn_auto_q        <= 1'b0;
            to_cnt            <= '0;
            rc_write_from_rom <= 1'b0;
            rc_reconfig       <= 1'b0;
            rc_reset          <= 1'b0;
            recfg             <= 1'b0;
            pos               <= POS_DEF;
            auto_on           <= 1'b0;
            auto_done         <= 1'b0;
            best_pos          <= POS_DEF;
        end else begin
            btn_up_q          <= btn_up;
            btn_down_q        <= btn_down;
            btn_auto_q        <= btn_auto;
            rc_write_from_rom <= 1'b0;
            rc_reconfig       <= 1'b0;
            rc_reset          <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending           <= 1'b0;
                        rc_write_from_rom <= 1'b1;
                        state             <= LOAD;
                    end
                end
                LOAD: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (!rc_busy) begin
                        rc_reconfig <= 1'b1;
                        to_cnt      <= TO_LOAD;
                        state       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    to_cnt <= to_nxt;
                    // The core has not raised busy yet in the rc_reconfig cycle, so ignore busy there.
                    if (to_fire) begin
                        rc_reset <= 1'b1;
                        state    <= IDLE;
                        if (!pending) recfg <= 1'b0;
                    end else if (!rc_reconfig && !rc_busy) begin
                        state <= IDLE;
                        if (!pending) recfg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new request overrides a same-cycle recfg drop / pending clear.
            if (req) begin
                pos     <= pos_req;
                auto_on <= auto_req;
                recfg   <= 1'b1;
                pending <= 1'b1;
                if (clr_done) auto_done <= 1'b0;
            end
            if (accept) begin
                auto_done <= 1'b1;
                best_pos  <= pos;
            end
        end
    end

    // Elapsed-time and dwell counters; all restart from zero on every reconfiguration.
    always_ff @(posedge clock_50_i) begin
        if (RESET || recfg) begin
            prescale <= '0;
            tick_cnt <= '0;
            mins     <= '0;
        end else begin
            prescale <= tick ? '0 : prescale + PS_ONE;
            if (tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    mins     <= bcd_inc(mins);
                end else begin
                    tick_cnt <= tick_cnt + 10'd1;
                end
            end
        end
        if (RESET || recfg || fail_nz || !auto_on || auto_done) begin
            dwell_cnt <= '0;
        end else if (tick) begin
            dwell_cnt <= dwell_cnt + DW_ONE;
        end
    end

    assign ticks = tick_cnt[2:0];

`ifdef PLL_SWEEP_STATS_EN
    always_ff @(posedge clock_50_i) begin
        if (RESET) begin
            to_count <= 8'h00;
        end else if (to_fire && to_count != 8'hFF) begin
            to_count <= to_count + 8'd1;
        end
    end
`else
    assign to_count = 8'h00;
`endif

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// Purpose : self-checking bench for pll_sweep_ctrl; expected handshake events are queued, a monitor pops them.
// Latency : n/a (bench).
// Backpress: rc_busy is modelled as a 5-cycle busy after rc_reconfig, or stuck high to force a timeout.
module tb_pll_sweep_ctrl;
    localparam int POS_W = 4;
    localparam int EV_WR = 0, EV_RC = 1, EV_RS = 2, EV_DONE = 3;
    localparam int BTN_UP = 0, BTN_DOWN = 1, BTN_AUTO = 2;
`ifdef PLL_SWEEP_STATS_EN
    localparam int TO_EXP = 1;
`else
    localparam int TO_EXP = 0;
`endif

    logic             clock_50_i, RESET;
    logic             btn_up, btn_down, btn_auto, start_auto, pass_nz, fail_nz, rc_busy;
    logic             rc_write_from_rom, rc_reconfig, rc_reset, recfg, auto_on, auto_done;
    logic [POS_W-1:0] pos, best_pos;
    logic [15:0]      mins;
    logic [2:0]       ticks;
    logic [7:0]       to_count;

    typedef struct {
        int kind;
        int pos;
        int delta;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic recfg_prev;
    bit   hang = 1'b0;
    bit   sweep_en = 1'b0;

    pll_sweep_ctrl #(
        .NUM_STEPS(11), .POS_W(POS_W), .DEF_POS(7), .CLK_HZ(100),
        .RECFG_TIMEOUT(1000), .DWELL_TICKS(5)
    ) dut (
        .clock_50_i(clock_50_i), .RESET(RESET),
        .btn_up(btn_up), .btn_down(btn_down), .btn_auto(btn_auto), .start_auto(start_auto),
        .pass_nz(pass_nz), .fail_nz(fail_nz), .rc_busy(rc_busy),
        .rc_write_from_rom(rc_write_from_rom), .rc_reconfig(rc_reconfig), .rc_reset(rc_reset),
        .recfg(recfg), .pos(pos), .auto_on(auto_on), .auto_done(auto_done), .best_pos(best_pos),
        .mins(mins), .ticks(ticks), .to_count(to_count)
    );

    initial begin
        clock_50_i = 1'b0;
        forever #5 clock_50_i = ~clock_50_i;
    end

    function automatic string kname(int k);
        case (k)
            EV_WR:   return "write_from_rom";
            EV_RC:   return "reconfig";
            EV_RS:   return "rc_reset";
            default: return "recfg_fall";
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(int k, int p, int d);
        exp_t e;
        e.kind  = k;
        e.pos   = p;
        e.delta = d;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(int k);
        exp_t e;
        int   d;
        d        = cyc - last_cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_%s: got event at pos %0d, expected none", kname(k), pos);
        end else begin
            e = exp_q.pop_front();
            check({"ev_kind_", kname(e.kind)}, k, e.kind);
            check({"ev_pos_", kname(e.kind)}, int'(pos), e.pos);
            if (e.delta >= 0) check({"ev_delta_", kname(e.kind)}, d, e.delta);
        end
    endtask

    // Monitor: every handshake pulse and every recfg fall must match the head of the queue.
    initial begin
        recfg_prev = 1'b0;
        forever begin
            @(negedge clock_50_i);
            cyc++;
            if (rc_write_from_rom === 1'b1) got_ev(EV_WR);
            if (rc_reconfig === 1'b1) got_ev(EV_RC);
            if (rc_reset === 1'b1) got_ev(EV_RS);
            if (recfg_prev === 1'b1 && recfg === 1'b0) got_ev(EV_DONE);
            recfg_prev = recfg;
        end
    end

    // pll_reconfig core model.
    initial begin
        forever begin
            @(negedge clock_50_i);
            if (rc_reconfig === 1'b1) begin
                rc_busy = 1'b1;
                if (!hang) begin
                    repeat (5) @(negedge clock_50_i);
                    rc_busy = 1'b0;
                end
            end
        end
    end

    // Tester model for the auto sweep: steps 0-2 fail, step 3 runs clean.
    initial begin
        forever begin
            @(negedge clock_50_i);
            if (sweep_en) begin
                pass_nz = 1'b1;
                fail_nz = (pos < 4'd3);
            end
        end
    end

    task automatic press(int which);
        @(negedge clock_50_i);
        case (which)
            BTN_UP:   btn_up = 1'b1;
            BTN_DOWN: btn_down = 1'b1;
            default:  btn_auto = 1'b1;
        endcase
        @(negedge clock_50_i);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_auto = 1'b0;
    endtask

    task automatic wait_drain(int budget, string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock_50_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_%s: %0d events still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_rc(int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock_50_i);
            n++;
        end while (rc_reconfig !== 1'b1 && n < budget);
        if (rc_reconfig !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_reconfig: rc_reconfig not seen within %0d cycles, required a pulse", budget);
        end
    endtask

    initial begin
        RESET = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0; start_auto = 1'b0;
        pass_nz = 1'b0; fail_nz = 1'b0; rc_busy = 1'b0;
        repeat (3) @(negedge clock_50_i);
        RESET = 1'b0;
        check("rst_pos", int'(pos), 7);
        check("rst_recfg", recfg, 0);
        check("rst_auto_on", auto_on, 0);
        check("rst_auto_done", auto_done, 0);
        check("rst_best_pos", int'(best_pos), 7);
        check("rst_mins", int'(mins), 0);
        check("rst_ticks", int'(ticks), 0);
        check("rst_to_count", int'(to_count), 0);
        check("rst_pulses", int'({rc_write_from_rom, rc_reconfig, rc_reset}), 0);

        repeat (100) @(negedge clock_50_i);
        check("idle_pos", int'(pos), 7);
        check("idle_recfg", recfg, 0);

        // Single step up with a well-behaved core.
        expect_ev(EV_WR, 6, -1); expect_ev(EV_RC, 6, 2); expect_ev(EV_DONE, 6, 6);
        press(BTN_UP);
        wait_drain(50, "up_6");
        check("up_pos", int'(pos), 6);
        check("up_recfg", recfg, 0);

        for (int p = 5; p >= 0; p--) begin
            expect_ev(EV_WR, p, -1); expect_ev(EV_RC, p, 2); expect_ev(EV_DONE, p, 6);
            press(BTN_UP);
            wait_drain(50, "up_loop");
        end
        press(BTN_UP);
        repeat (20) @(negedge clock_50_i);
        check("up_at_0_pos", int'(pos), 0);
        check("up_at_0_recfg", recfg, 0);

        for (int p = 1; p <= 10; p++) begin
            expect_ev(EV_WR, p, -1); expect_ev(EV_RC, p, 2); expect_ev(EV_DONE, p, 6);
            press(BTN_DOWN);
            wait_drain(50, "down_loop");
        end
        press(BTN_DOWN);
        repeat (20) @(negedge clock_50_i);
        check("down_at_10_pos", int'(pos), 10);
        check("down_at_10_recfg", recfg, 0);

        // Core never drops busy: timeout path.
        hang = 1'b1;
        expect_ev(EV_WR, 9, -1); expect_ev(EV_RC, 9, 2); expect_ev(EV_RS, 9, 999); expect_ev(EV_DONE, 9, 0);
        press(BTN_UP);
        wait_drain(1100, "timeout");
        hang = 1'b0;
        rc_busy = 1'b0;
        check("timeout_to_count", int'(to_count), TO_EXP);
        expect_ev(EV_WR, 8, -1); expect_ev(EV_RC, 8, 2); expect_ev(EV_DONE, 8, 6);
        press(BTN_UP);
        wait_drain(50, "after_timeout");
        check("after_timeout_pos", int'(pos), 8);

        // Second request during WAIT_DONE: back-to-back handshakes, recfg never drops in between.
        expect_ev(EV_WR, 9, -1); expect_ev(EV_RC, 9, 2);
        expect_ev(EV_WR, 10, 7); expect_ev(EV_RC, 10, 2); expect_ev(EV_DONE, 10, 6);
        press(BTN_DOWN);
        wait_rc(20);
        press(BTN_DOWN);
        wait_drain(80, "back_to_back");
        check("b2b_pos", int'(pos), 10);
        check("b2b_recfg", recfg, 0);

        // Auto sweep from step 0, first clean step is 3.
        sweep_en = 1'b1;
        expect_ev(EV_WR, 0, -1); expect_ev(EV_RC, 0, 2); expect_ev(EV_DONE, 0, 6);
        for (int p = 1; p <= 3; p++) begin
            expect_ev(EV_WR, p, 2); expect_ev(EV_RC, p, 2); expect_ev(EV_DONE, p, 6);
        end
        @(negedge clock_50_i);
        start_auto = 1'b1;
        @(negedge clock_50_i);
        start_auto = 1'b0;
        wait_drain(200, "auto_sweep");
        check("sweep_pos", int'(pos), 3);
        check("sweep_done_early", auto_done, 0);
        check("sweep_auto_on", auto_on, 1);
        repeat (100) @(negedge clock_50_i);
        check("sweep_auto_done", auto_done, 1);
        check("sweep_best_pos", int'(best_pos), 3);
        check("sweep_pos_final", int'(pos), 3);
        check("sweep_recfg", recfg, 0);

        // One minute of clean running.
        repeat (6000) @(negedge clock_50_i);
        check("mins_one", int'(mins), 16'h0001);

        sweep_en = 1'b0;
        @(negedge clock_50_i);
        pass_nz = 1'b0;
        fail_nz = 1'b0;
        expect_ev(EV_WR, 3, -1); expect_ev(EV_RC, 3, 2); expect_ev(EV_DONE, 3, 6);
        press(BTN_AUTO);
        wait_drain(50, "auto_off");
        check("auto_off_auto_on", auto_on, 0);
        check("auto_off_pos", int'(pos), 3);
        check("auto_off_mins", int'(mins), 0);

        // Reset in the middle of a handshake: no rc_reset, back to defaults.
        expect_ev(EV_WR, 4, -1); expect_ev(EV_RC, 4, 2);
        press(BTN_DOWN);
        wait_drain(30, "pre_reset");
        expect_ev(EV_DONE, 7, -1);
        @(negedge clock_50_i);
        RESET = 1'b1;
        @(negedge clock_50_i);
        RESET = 1'b0;
        wait_drain(10, "reset_mid");
        repeat (30) @(negedge clock_50_i);
        check("reset_mid_pos", int'(pos), 7);
        check("reset_mid_recfg", recfg, 0);
        check("reset_mid_best_pos", int'(best_pos), 7);
        check("reset_mid_to_count", int'(to_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_sweep_ctrl.md
Name: pll_sweep_ctrl

Overview:
- Control block for the SDRAM memtest frequency sweep, in the clock_50_i domain.
- Holds the current frequency-step index and runs the PLL-reconfig ROM handshake, including timeout recovery.
- Provides manual up/down stepping and an automatic sweep that stops at the first step surviving a configurable dwell time without failures.
- Maintains BCD elapsed minutes and a 100 ms tick counter; both clear on every reconfiguration.

Parameters:
- NUM_STEPS, 11: number of PLL configurations; index 0 is the fastest.
- POS_W, 4: width of the step index. Must satisfy 2^POS_W >= NUM_STEPS.
- DEF_POS, 7: step index after reset.
- CLK_HZ, 50000000: clock_50_i frequency in Hz.
- RECFG_TIMEOUT, 1000: cycles allowed in WAIT_DONE before the reconfig core is forcibly reset.
- DWELL_TICKS, 600: 100 ms ticks a step must run fail-free for auto mode to accept it (default 60 s).

Ports:
- clock_50_i  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- btn_up  in  1  debounced level; a rising edge steps to a faster configuration (pos-1).
- btn_down  in  1  debounced level; a rising edge steps to a slower configuration (pos+1).
- btn_auto  in  1  debounced level; a rising edge toggles auto mode.
- start_auto  in  1  level; forces auto mode and restarts the sweep at pos 0.
- pass_nz  in  1  tester passcount is nonzero; already synchronised to clock_50_i.
- fail_nz  in  1  tester failcount is nonzero; already synchronised to clock_50_i.
- rc_busy  in  1  busy flag from the pll_reconfig core.
- rc_write_from_rom  out  1  one-cycle pulse.
- rc_reconfig  out  1  one-cycle pulse.
- rc_reset  out  1  one-cycle pulse.
- recfg  out  1  high from an accepted request until the handshake completes; also holds the tester in reset.
- pos  out  POS_W  current step index; also selects the reconfig ROM.
- auto_on  out  1  auto mode active.
- auto_done  out  1  auto sweep has finished.
- best_pos  out  POS_W  step accepted by the last auto sweep.
- mins  out  16  4-digit BCD elapsed minutes.
- ticks  out  3  low 3 bits of the 100 ms tick count.
- to_count  out  8  reconfig timeout count (see Optional Feature).

Behaviour:
- Reset values: pos=DEF_POS, recfg=0, auto_on=0, auto_done=0, best_pos=DEF_POS, mins=0, ticks=0, to_count=0, all rc_* pulses=0, FSM in IDLE.
- Button inputs are edge-detected with a 1-cycle registered copy. An event is acted on in the cycle after the edge.
- Request priority within one cycle (highest first):
  - start_auto: pos=0, auto_on=1, auto_done=0.
  - btn_auto edge with auto_on=1: auto_on=0, pos unchanged, reconfig requested.
  - btn_auto edge with auto_on=0: pos=0, auto_on=1, auto_done=0.
  - btn_up: only if pos>0; pos=pos-1, auto_on=0.
  - btn_down: only if pos<NUM_STEPS-1; pos=pos+1, auto_on=0.
  - auto advance.
- An out-of-range up/down press is ignored: no reconfig, no change.
- Every accepted request sets recfg=1 and the pending flag.
- Requests accepted while the FSM is not in IDLE only set pending. The handshake re-runs for the latest pos once the current one completes.
- FSM:
  - IDLE: if pending, clear pending, pulse rc_write_from_rom, go to LOAD.
  - LOAD: 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: when rc_busy=0, pulse rc_reconfig, load the timeout counter with RECFG_TIMEOUT, go to WAIT_DONE.
  - WAIT_DONE: decrement the counter each cycle.
    - In a cycle after the rc_reconfig pulse where rc_busy=0: go to IDLE.
    - If the counter reaches 1 first: pulse rc_reset, go to IDLE.
    - If both happen in the same cycle, the timeout path wins and rc_reset is pulsed.
  - recfg drops in the cycle the FSM enters IDLE with pending=0.
- Auto advance fires when all of these hold: auto_on=1, auto_done=0, recfg=0, pass_nz=1, fail_nz=1.
  - pos<NUM_STEPS-1: pos=pos+1 and reconfig.
  - pos=NUM_STEPS-1: auto_done=1, best_pos=pos, auto_on stays 1.
- Dwell: in auto mode with recfg=0 and fail_nz=0, count 100 ms ticks. On reaching DWELL_TICKS: auto_done=1, best_pos=pos. The dwell count clears on recfg or fail_nz.
- Timers:
  - 100 ms tick every CLK_HZ/10 cycles.
  - mins increments every 600 ticks with a BCD ripple carry; 9999 wraps to 0000.
  - recfg=1 holds the tick prescaler, the tick count, the dwell count and mins at 0.
- RESET asserted mid-handshake returns the FSM to IDLE next cycle with no rc_reset pulse. pos returns to DEF_POS.

Optional Feature:
- Macro: PLL_SWEEP_STATS_EN.
- Defined: to_count increments, saturating at 255, on each WAIT_DONE timeout. It clears only on RESET.
- Undefined: to_count is tied to 0 and the counter logic is absent.

Test Plan:
- RESET, then idle 100 cycles -> pos=7, recfg=0, no rc_* pulse.
- btn_up edge with rc_busy=0, rc_busy pulses high 5 cycles after rc_reconfig -> pos=6, sequence write_from_rom, 1 cycle, rc_reconfig, recfg low once rc_busy falls.
- pos=0, btn_up edge -> no change, no reconfig. pos=10, btn_down edge -> no change, no reconfig.
- rc_busy held 1 after rc_reconfig -> rc_reset pulse 999 cycles after rc_reconfig, FSM back to IDLE; with PLL_SWEEP_STATS_EN, to_count=1.
- start_auto, then pass_nz=fail_nz=1 at steps 0-2, fail_nz=0 at step 3 with DWELL_TICKS=5 (CLK_HZ reduced for sim) -> pos steps 0,1,2,3, auto_done=1, best_pos=3.
- btn_down edge during WAIT_DONE -> second handshake runs immediately after the first, final pos=old+1, recfg continuous throughout.
